mdu_hilo: RTL and testbench

MDU_HILO -- requirements
Module: mdu_hilo

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_div.sv | 72 +++++++
 rtl/mdu_hilo.sv | 125 ++++++++++++
 tb/tb_mdu_hilo.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states,
// latencies and the 32x32->64 product helper.
package mdu_pkg;

  localparam logic [4:0] OP_MULTU = 5'd5;
  localparam logic [4:0] OP_MULT  = 5'd6;
  localparam logic [4:0] OP_DIVU  = 5'd7;
  localparam logic [4:0] OP_DIV   = 5'd8;
  localparam logic [4:0] OP_MFHI  = 5'd9;
  localparam logic [4:0] OP_MFLO  = 5'd10;
  localparam logic [4:0] OP_MTHI  = 5'd11;
  localparam logic [4:0] OP_MTLO  = 5'd12;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  // Extending both operands to 64 bits makes the low 64 bits of the product
  // correct for signed and unsigned operands alike.
  function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                        input logic sgn);
    logic [63:0] ex;
    logic [63:0] ey;
    ex = {{32{sgn & x[31]}}, x};
    ey = {{32{sgn & y[31]}}, y};
    return ex * ey;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Iterative restoring divider, one quotient bit per cycle, with signed fix-up.
// The last iteration is combinational so results are ready on the 32nd edge.
module mdu_div
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;
  logic        run;
  logic [4:0]  cnt;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvs};
    if (diff[32]) begin
      rem_step = shifted[31:0];
      quo_step = {quo[30:0], 1'b0};
    end else begin
      rem_step = diff[31:0];
      quo_step = {quo[30:0], 1'b1};
    end
  end

  assign done      = run & (cnt == 5'd0);
  assign quotient  = neg_q ? -quo_step : quo_step;
  assign remainder = neg_r ? -rem_step : rem_step;

  // A zero divisor never restores, giving an all-ones quotient and rem = |a|.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      run   <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      quo   <= (sgn & a[31]) ? -a : a;
      dvs   <= (sgn & b[31]) ? -b : b;
      rem   <= '0;
      neg_q <= sgn & (a[31] ^ b[31]);
      neg_r <= sgn & a[31];
      cnt   <= 5'(DIV_LAT - 1);
      run   <= 1'b1;
    end else if (run) begin
      rem <= rem_step;
      quo <= quo_step;
      if (cnt == 5'd0) run <= 1'b0;
      else             cnt <= cnt - 5'd1;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// MIPS-style HI/LO multiply/divide unit. Define MDU_FAST_MULT_EN for
// single-edge multiplies; otherwise mult/multu take MUL_LAT cycles.
module mdu_hilo
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_en,
  input  logic [4:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state;
  state_t      state_next;
  logic [4:0]  count;
  logic [4:0]  count_next;
  logic [31:0] hi_next;
  logic [31:0] lo_next;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_sgn;
  logic        latch_mul;
  logic        div_start;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  mdu_div u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .sgn       (md_op == OP_DIV),
    .a         (a),
    .b         (b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign busy   = (state != S_IDLE);
  assign stall  = md_en & busy;
  assign md_out = (md_op == OP_MFHI) ? hi : (md_op == OP_MFLO) ? lo : 32'd0;

  always_comb begin
    state_next = state;
    count_next = count;
    hi_next    = hi;
    lo_next    = lo;
    latch_mul  = 1'b0;
    div_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if (md_en) begin
          case (md_op)
            OP_MTHI: hi_next = a;
            OP_MTLO: lo_next = a;
            OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MULT_EN
              {hi_next, lo_next} = mul64(a, b, md_op == OP_MULT);
`else
              latch_mul  = 1'b1;
              state_next = S_MUL;
              count_next = 5'(MUL_LAT - 1);
`endif
            end
            OP_DIV, OP_DIVU: begin
              div_start  = 1'b1;
              state_next = S_DIV;
              count_next = 5'(DIV_LAT - 1);
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (count == 5'd0) begin
          {hi_next, lo_next} = mul64(mul_a, mul_b, mul_sgn);
          state_next         = S_IDLE;
        end else begin
          count_next = count - 5'd1;
        end
      end
      S_DIV: begin
        // div_done coincides with count reaching zero.
        if (div_done) begin
          hi_next    = div_r;
          lo_next    = div_q;
          state_next = S_IDLE;
        end else begin
          count_next = count - 5'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_sgn <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      hi    <= hi_next;
      lo    <= lo_next;
      if (latch_mul) begin
        mul_a   <= a;
        mul_b   <= b;
        mul_sgn <= (md_op == OP_MULT);
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo; expected values are hand-computed.
// Honours MDU_FAST_MULT_EN for the expected multiply latency.
module tb_mdu_hilo;
  import mdu_pkg::*;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_L = 0;
`else
  localparam int MUL_L = 5;
`endif

  logic        clk;
  logic        rst_n;
  logic        md_en;
  logic [4:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;

  mdu_hilo dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .md_en  (md_en),
    .md_op  (md_op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .stall  (stall),
    .md_out (md_out),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operands are scrambled right after the accept edge to prove they were latched.
  task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    md_en = 1'b1;
    md_op = op;
    a     = x;
    b     = y;
    tick();
    md_en = 1'b0;
    a     = 32'hA5A5A5A5;
    b     = 32'h5A5A5A5A;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    md_en = 1'b0;
    md_op = 5'd0;
    a     = '0;
    b     = '0;
    #3;
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo);
    end
    vectors++;
    if (busy !== 1'b0 || stall !== 1'b0 || md_out !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: busy=%b stall=%b md_out=%h required 0/0/0", busy, stall, md_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_move();
    issue(OP_MTHI, 32'h12345678, 32'h0);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mthi_busy: busy=%b required 0", busy);
    end
    md_en = 1'b1;
    md_op = OP_MFHI;
    #1;
    vectors++;
    if (md_out !== 32'h12345678 || stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mfhi: md_out=%h stall=%b required 12345678/0", md_out, stall);
    end
    md_en = 1'b0;
    issue(OP_MTLO, 32'hCAFEF00D, 32'h0);
    md_op = OP_MFLO;
    #1;
    vectors++;
    if (md_out !== 32'hCAFEF00D || hi !== 32'h12345678) begin
      miscompares++;
      $display("[TB] FAIL mflo: md_out=%h hi=%h required cafef00d/12345678", md_out, hi);
    end
    issue(5'd20, 32'hFFFFFFFF, 32'hFFFFFFFF);
    md_op = 5'd0;
    #1;
    vectors++;
    if (hi !== 32'h12345678 || lo !== 32'hCAFEF00D || busy !== 1'b0 || md_out !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL unknown_op: hi=%h lo=%h busy=%b md_out=%h required 12345678/cafef00d/0/0",
               hi, lo, busy, md_out);
    end
  endtask

  task automatic test_mult();
    int n;
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    vectors++;
    if (n !== MUL_L || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      miscompares++;
      $display("[TB] FAIL mult: cycles=%0d hi=%h lo=%h required %0d/ffffffff/fffffffa", n, hi, lo, MUL_L);
    end
    issue(OP_MULTU, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    vectors++;
    if (n !== MUL_L || hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
      miscompares++;
      $display("[TB] FAIL multu: cycles=%0d hi=%h lo=%h required %0d/00000002/fffffffa", n, hi, lo, MUL_L);
    end
  endtask

  task automatic test_div_signed();
    int n;
    int stall_cycles;
    logic [31:0] hi_mid;
    hi_mid = 'x;
    stall_cycles = 0;
    n = 0;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    md_en = 1'b1;
    md_op = OP_MFLO;
    while (busy && n < 200) begin
      if (stall) stall_cycles++;
      if (n == 5) hi_mid = hi;
      tick();
      n++;
    end
    vectors++;
    if (n !== 32 || stall_cycles !== 32) begin
      miscompares++;
      $display("[TB] FAIL div_latency: busy=%0d stall=%0d required 32/32", n, stall_cycles);
    end
    vectors++;
    if (hi_mid !== 32'h00000002) begin
      miscompares++;
      $display("[TB] FAIL div_hold: hi during busy=%h required 00000002", hi_mid);
    end
    vectors++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || md_out !== 32'hFFFFFFFD || stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL div_signed: lo=%h hi=%h md_out=%h stall=%b required fffffffd/ffffffff/fffffffd/0",
               lo, hi, md_out, stall);
    end
    tick();
    md_en = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mflo_after_div: busy=%b required 0", busy);
    end
  endtask

  task automatic test_div_edge();
    int n;
    issue(OP_DIVU, 32'd100, 32'd0);
    tick();
    tick();
    tick();
    md_en = 1'b1;
    md_op = OP_MTHI;
    a     = 32'hDEADBEEF;
    tick();
    tick();
    tick();
    vectors++;
    if (hi !== 32'hFFFFFFFF || busy !== 1'b1 || stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ignore_while_busy: hi=%h busy=%b stall=%b required ffffffff/1/1", hi, busy, stall);
    end
    md_en = 1'b0;
    wait_idle(n);
    vectors++;
    if (n !== 26 || lo !== 32'hFFFFFFFF || hi !== 32'd100) begin
      miscompares++;
      $display("[TB] FAIL divu_by_zero: rest=%0d lo=%h hi=%h required 26/ffffffff/00000064", n, lo, hi);
    end
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    vectors++;
    if (n !== 32 || lo !== 32'h80000000 || hi !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL div_overflow: cycles=%0d lo=%h hi=%h required 32/80000000/00000000", n, lo, hi);
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_midflight: hi=%h lo=%h busy=%b required 0/0/0", hi, lo, busy);
    end
    tick();
    rst_n = 1'b1;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    vectors++;
    if (n !== 32 || lo !== 32'd14 || hi !== 32'd2) begin
      miscompares++;
      $display("[TB] FAIL divu_after_reset: cycles=%0d lo=%0d hi=%0d required 32/14/2", n, lo, hi);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int stall_cycles;
    stall_cycles = 0;
    n = 0;
    issue(OP_MULT, 32'd3, 32'd4);
    md_en = 1'b1;
    md_op = OP_MFLO;
    while (busy && n < 200) begin
      if (stall) stall_cycles++;
      tick();
      n++;
    end
    vectors++;
    if (stall_cycles !== MUL_L || md_out !== 32'd12 || stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_mult_mflo: stall=%0d md_out=%0d required %0d/12", stall_cycles, md_out, MUL_L);
    end
    issue(OP_DIVU, 32'd1000, 32'd7);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_issue: busy=%b required 1", busy);
    end
    wait_idle(n);
    vectors++;
    if (n !== 32 || lo !== 32'd142 || hi !== 32'd6) begin
      miscompares++;
      $display("[TB] FAIL b2b_divu: cycles=%0d lo=%0d hi=%0d required 32/142/6", n, lo, hi);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_move();
    test_mult();
    test_div_signed();
    test_div_edge();
    test_reset_midflight();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
